// File: rtl/uart_rx.sv
// 8N1 UART receiver with a valid/ready holding register; baud timing from CLKS_PER_BIT.
// Optional even-parity bit and parity_err output when UART_RX_PARITY_EN is defined.
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 uart_rx_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun_err,
    output logic                 busy
`ifdef UART_RX_PARITY_EN
    ,
    output logic                 parity_err
`endif
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned IDX_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t               state, state_n;
    logic                 rx_meta, rx_sync, rx_prev;
    logic [CNT_W-1:0]     cnt, cnt_n;
    logic [IDX_W-1:0]     bit_idx, bit_idx_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic [DATA_BITS-1:0] rx_data_n;
    logic                 rx_valid_n, frame_err_n, overrun_err_n, busy_n;
    logic                 par_fail;
`ifdef UART_RX_PARITY_EN
    logic                 par_bit, par_bit_n, parity_err_n;
`endif

    // State, synchronizer and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta     <= 1'b1;
            rx_sync     <= 1'b1;
            rx_prev     <= 1'b1;
            state       <= IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
            busy        <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit     <= 1'b0;
            parity_err  <= 1'b0;
`endif
        end else begin
            rx_meta     <= uart_rx_in;
            rx_sync     <= rx_meta;
            rx_prev     <= rx_sync;
            state       <= state_n;
            cnt         <= cnt_n;
            bit_idx     <= bit_idx_n;
            shreg       <= shreg_n;
            rx_data     <= rx_data_n;
            rx_valid    <= rx_valid_n;
            frame_err   <= frame_err_n;
            overrun_err <= overrun_err_n;
            busy        <= busy_n;
`ifdef UART_RX_PARITY_EN
            par_bit     <= par_bit_n;
            parity_err  <= parity_err_n;
`endif
        end
    end

    // Next-state and output logic
    always_comb begin
        state_n       = state;
        cnt_n         = cnt;
        bit_idx_n     = bit_idx;
        shreg_n       = shreg;
        rx_data_n     = rx_data;
        rx_valid_n    = rx_valid & ~rx_ready;
        frame_err_n   = 1'b0;
        overrun_err_n = 1'b0;
        par_fail      = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bit_n     = par_bit;
        parity_err_n  = 1'b0;
`endif

        case (state)
            IDLE: begin
                if (rx_prev && !rx_sync) begin
                    state_n = START;
                    cnt_n   = '0;
                end
            end
            START: begin
                // Mid start bit: a high sample means the edge was a glitch
                if (cnt == CNT_HALF) begin
                    cnt_n     = '0;
                    bit_idx_n = '0;
                    state_n   = rx_sync ? IDLE : DATA;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            DATA: begin
                if (cnt == CNT_LAST) begin
                    cnt_n   = '0;
                    shreg_n = {rx_sync, shreg[DATA_BITS-1:1]};
                    if (bit_idx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end else begin
                        bit_idx_n = bit_idx + 1'b1;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt == CNT_LAST) begin
                    cnt_n     = '0;
                    par_bit_n = rx_sync;
                    state_n   = STOP;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
`endif
            STOP: begin
                if (cnt == CNT_LAST) begin
                    cnt_n   = '0;
                    state_n = IDLE;
`ifdef UART_RX_PARITY_EN
                    par_fail     = ^{shreg, par_bit};
                    parity_err_n = par_fail;
`endif
                    frame_err_n = ~rx_sync;
                    // Load when empty or drained this cycle, else drop and flag overrun
                    if (rx_sync && !par_fail) begin
                        if (!rx_valid || rx_ready) begin
                            rx_data_n  = shreg;
                            rx_valid_n = 1'b1;
                        end else begin
                            overrun_err_n = 1'b1;
                        end
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase

        busy_n = (state_n != IDLE);
    end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx (CLKS_PER_BIT=16): directed frames, monitor pops expected bytes on handshakes.
module tb_uart_rx;

    localparam int unsigned CPB = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       uart_rx_in;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun_err;
    logic       busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .uart_rx_in  (uart_rx_in),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .frame_err   (frame_err),
        .overrun_err (overrun_err),
        .busy        (busy)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_err  (parity_err)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] exp_q[$];
    int         n_pushed = 0;

    int n_rise = 0, last_rise = 0;
    int n_fe = 0, fe_hi = 0, n_ov = 0, ov_hi = 0, n_pe = 0, pe_hi = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        exp_q.push_back(b);
        n_pushed++;
    endtask

    task automatic hold(input logic v, input int n);
        uart_rx_in = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic stop_bit, input logic par_flip);
        hold(1'b0, CPB);
        for (int i = 0; i < 8; i++) hold(b[i], CPB);
`ifdef UART_RX_PARITY_EN
        hold(^b ^ par_flip, CPB);
`else
        if (par_flip) $display("note: parity flip ignored in 8N1 build");
`endif
        hold(stop_bit, CPB);
    endtask

    // Monitor: compare every handshake against the scoreboard, count flag pulses
    initial begin
        logic pv, pfe, pov, ppe;
        logic [7:0] e;
        pv = 0; pfe = 0; pov = 0; ppe = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (rx_valid && rx_ready) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_byte: got 0x%0h, expected none", rx_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("rx_data", 32'(rx_data), 32'(e));
                    end
                end
                if (rx_valid && !pv) begin
                    n_rise++;
                    last_rise = cyc;
                end
                if (frame_err && !pfe) n_fe++;
                if (overrun_err && !pov) n_ov++;
                fe_hi += int'(frame_err);
                ov_hi += int'(overrun_err);
`ifdef UART_RX_PARITY_EN
                if (parity_err && !ppe) n_pe++;
                pe_hi += int'(parity_err);
                ppe = parity_err;
`endif
            end
            pv  = rx_valid;
            pfe = frame_err;
            pov = overrun_err;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t0, r0, f0, fh0, o0, oh0, p0, ph0;
        logic busy_any;

        rst = 1'b1;
        uart_rx_in = 1'b1;
        rx_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_rx_valid", 32'(rx_valid), 0);
        check("reset_busy", 32'(busy), 0);
        check("reset_frame_err", 32'(frame_err), 0);
        check("reset_overrun_err", 32'(overrun_err), 0);
        check("reset_rx_data", 32'(rx_data), 0);
        rst = 1'b0;
        hold(1'b1, 4);

        // Single byte with latency check
        rx_ready = 1'b1;
        push(8'hA5);
        r0 = n_rise;
        t0 = cyc;
        send(8'hA5, 1'b1, 1'b0);
        hold(1'b1, 4);
        check("a5_valid_rose", 32'(n_rise - r0), 1);
        check("a5_latency_ok", 32'((last_rise - t0 >= 154) && (last_rise - t0 <= 156)), 1);
        check("a5_frame_err", 32'(n_fe), 0);

        // Back-to-back frames, consumer always ready
        o0 = n_ov;
        push(8'h00); push(8'hFF); push(8'h3C);
        send(8'h00, 1'b1, 1'b0);
        send(8'hFF, 1'b1, 1'b0);
        send(8'h3C, 1'b1, 1'b0);
        hold(1'b1, 4);
        check("b2b_no_overrun", 32'(n_ov - o0), 0);
        check("b2b_queue_drained", 32'(exp_q.size()), 0);

        // Overrun: second byte dropped, first kept
        rx_ready = 1'b0;
        o0 = n_ov; oh0 = ov_hi;
        push(8'h55);
        send(8'h55, 1'b1, 1'b0);
        send(8'h81, 1'b1, 1'b0);
        hold(1'b1, 5);
        check("ovr_pulses", 32'(n_ov - o0), 1);
        check("ovr_pulse_width", 32'(ov_hi - oh0), 1);
        check("ovr_rx_data_kept", 32'(rx_data), 32'h55);
        check("ovr_rx_valid_held", 32'(rx_valid), 1);
        rx_ready = 1'b1;
        @(posedge clk);
        #1;
        check("ovr_drain_valid_low", 32'(rx_valid), 0);
        hold(1'b1, 4);

        // Framing error, then a held-low line must not retrigger
        r0 = n_rise; f0 = n_fe; fh0 = fe_hi;
        send(8'h12, 1'b0, 1'b0);
        busy_any = 1'b0;
        uart_rx_in = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            busy_any |= busy;
        end
        check("fe_pulses", 32'(n_fe - f0), 1);
        check("fe_pulse_width", 32'(fe_hi - fh0), 1);
        check("fe_no_valid", 32'(n_rise - r0), 0);
        check("fe_low_line_no_start", 32'(busy_any), 0);
        hold(1'b1, 20);
        push(8'h34);
        send(8'h34, 1'b1, 1'b0);
        hold(1'b1, 4);
        check("after_fe_34_delivered", 32'(n_rise - r0), 1);

        // 3-cycle glitch on idle line
        r0 = n_rise; f0 = n_fe; o0 = n_ov;
        busy_any = 1'b0;
        uart_rx_in = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            busy_any |= busy;
        end
        uart_rx_in = 1'b1;
        repeat (30) begin
            @(posedge clk);
            #1;
            busy_any |= busy;
        end
        check("glitch_started", 32'(busy_any), 1);
        check("glitch_back_idle", 32'(busy), 0);
        check("glitch_no_valid", 32'(n_rise - r0), 0);
        check("glitch_no_flags", 32'((n_fe - f0) + (n_ov - o0)), 0);

        // Reset in the middle of 0x77's data bits
        r0 = n_rise;
        hold(1'b0, CPB);
        for (int i = 0; i < 4; i++) hold(8'h77 >> i & 8'h01 ? 1'b1 : 1'b0, CPB);
        hold(1'b1, CPB / 2);
        check("mid_frame_busy", 32'(busy), 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_rx_valid", 32'(rx_valid), 0);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_rx_data", 32'(rx_data), 0);
        check("midrst_flags", 32'({frame_err, overrun_err}), 0);
        rst = 1'b0;
        hold(1'b1, 200);
        check("midrst_no_byte", 32'(n_rise - r0), 0);

`ifdef UART_RX_PARITY_EN
        r0 = n_rise; p0 = n_pe; ph0 = pe_hi; f0 = n_fe;
        push(8'hA5);
        send(8'hA5, 1'b1, 1'b0);
        hold(1'b1, 4);
        check("par_good_accepted", 32'(n_rise - r0), 1);
        check("par_good_no_err", 32'(n_pe - p0), 0);
        send(8'hA5, 1'b1, 1'b1);
        hold(1'b1, 4);
        check("par_bad_pulses", 32'(n_pe - p0), 1);
        check("par_bad_width", 32'(pe_hi - ph0), 1);
        check("par_bad_no_valid", 32'(n_rise - r0), 1);
        check("par_bad_no_fe", 32'(n_fe - f0), 0);
`else
        p0 = 0; ph0 = 0;
`endif

        check("total_deliveries", 32'(n_rise), 32'(n_pushed));
        check("scoreboard_empty", 32'(exp_q.size()), 0);
        check("total_overruns", 32'(n_ov), 1);
        check("total_frame_errs", 32'(n_fe), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
